scarv_soc_bram_dual_pipe: RTL

Parametrised dual-port block RAM simulation model for the SoC memory subsystem, successor to the fixed 32-bit, single-cycle dual-port model. Adds:
- configurable data width;
- configurable read latency with per-port valid strobes;
- selectable read-during-write semantics;
- deterministic resolution of same-word write collisions, with an optional collision monitor.

It sits behind the SoC interconnect memory ports for RAM and ROM regions in simulation builds only.

---
 rtl/scarv_soc_bram_dual_pipe.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/scarv_soc_bram_dual_pipe.sv
// scarv_soc_bram_dual_pipe: parametrised dual-port byte-addressed RAM/ROM model
// with configurable read latency, per-port valid strobes, selectable
// read-during-write behaviour and port-A-wins write collision resolution.
// Optional collision monitor: define SCARV_SOC_BRAM_COLLISION_CHECK_EN.
module scarv_soc_bram_dual_pipe #(
  parameter int    WRITE_EN   = 1,
  parameter int    DEPTH      = 4096,
  parameter int    DW         = 32,
  parameter int    RD_LATENCY = 1,
  parameter int    RDW_MODE   = 0,
  parameter string MEMH_FILE  = ""
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     ena,
  input  logic [DW/8-1:0]          wea,
  input  logic [$clog2(DEPTH)-1:0] addra,
  input  logic [DW-1:0]            dina,
  output logic [DW-1:0]            douta,
  output logic                     valida,
  input  logic                     enb,
  input  logic [DW/8-1:0]          web,
  input  logic [$clog2(DEPTH)-1:0] addrb,
  input  logic [DW-1:0]            dinb,
  output logic [DW-1:0]            doutb,
  output logic                     validb,
  output logic                     collision,
  output logic [15:0]              collision_count
);

  localparam int NB    = DW / 8;
  localparam int LW    = $clog2(DEPTH);
  localparam int NBL   = $clog2(NB);
  localparam int AW    = LW - NBL;
  localparam int WORDS = DEPTH / NB;
  localparam int L     = RD_LATENCY;

  logic [DW-1:0] mem [WORDS];

  // Both ports packed side by side: index 0 is port A, index 1 is port B.
  logic [1:0]          en;
  logic [1:0][AW-1:0]  idx;
  logic [1:0][NB-1:0]  wr;
  logic [1:0][DW-1:0]  din;
  logic [1:0][DW-1:0]  rd_word;
  logic [1:0][DW-1:0]  dout_w;
  logic [1:0]          vld_w;

  assign en     = {enb, ena};
  assign idx[0] = addra[LW-1:NBL];
  assign idx[1] = addrb[LW-1:NBL];
  assign din    = {dinb, dina};
  // A ROM build never writes; a disabled port never writes.
  assign wr[0]  = ((WRITE_EN != 0) && ena) ? wea : '0;
  assign wr[1]  = ((WRITE_EN != 0) && enb) ? web : '0;

  // Byte-offset address bits only select a lane inside the word.
  if (NBL > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{addra[NBL-1:0], addrb[NBL-1:0]};
  end

  // Lane writes; A is applied last so it wins lanes both ports write.
  always_ff @(posedge clka) begin
    if (!rsta) begin
      for (int i = 0; i < NB; i++) begin
        if (wr[1][i]) mem[idx[1]][8*i +: 8] <= din[1][8*i +: 8];
        if (wr[0][i]) mem[idx[0]][8*i +: 8] <= din[0][8*i +: 8];
      end
    end
  end

  // Read word per port: stored contents, or post-write merge in write-first mode.
  always_comb begin
    rd_word = '0;
    for (int p = 0; p < 2; p++) begin
      rd_word[p] = mem[idx[p]];
      if (RDW_MODE != 0) begin
        for (int i = 0; i < NB; i++) begin
          if (wr[0][i] && (idx[0] == idx[p]))
            rd_word[p][8*i +: 8] = din[0][8*i +: 8];
          else if (wr[1][i] && (idx[1] == idx[p]))
            rd_word[p][8*i +: 8] = din[1][8*i +: 8];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [L-1:0]  vld_reg;
      logic [DW-1:0] dat_reg [L];

      // Read pipeline: data only advances with its valid so the output holds.
      always_ff @(posedge clka or posedge rsta) begin
        if (rsta) begin
          vld_reg <= '0;
          for (int s = 0; s < L; s++) dat_reg[s] <= '0;
        end else begin
          vld_reg[0] <= en[gi];
          if (en[gi]) dat_reg[0] <= rd_word[gi];
          for (int s = 1; s < L; s++) begin
            vld_reg[s] <= vld_reg[s-1];
            if (vld_reg[s-1]) dat_reg[s] <= dat_reg[s-1];
          end
        end
      end

      assign dout_w[gi] = dat_reg[L-1];
      assign vld_w[gi]  = vld_reg[L-1];
    end
  endgenerate

  assign douta  = dout_w[0];
  assign doutb  = dout_w[1];
  assign valida = vld_w[0];
  assign validb = vld_w[1];

`ifdef SCARV_SOC_BRAM_COLLISION_CHECK_EN
  logic        coll_event;
  logic        collision_reg;
  logic [15:0] count_reg;

  assign coll_event = ena && enb && (idx[0] == idx[1]) && ((|wr[0]) || (|wr[1]));

  // One-cycle pulse and saturating event counter, reported as they happen.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      collision_reg <= 1'b0;
      count_reg     <= '0;
    end else begin
      collision_reg <= coll_event;
      if (coll_event) begin
        if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
        $display("%0t: bram collision addra=0x%0h addrb=0x%0h", $time, addra, addrb);
      end
    end
  end

  assign collision       = collision_reg;
  assign collision_count = count_reg;
`else
  assign collision       = 1'b0;
  assign collision_count = '0;
`endif

endmodule
